// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: the pipeline's hazard-relevant stage signals
// plus the hold/bubble/flush enables returned to the pipeline registers.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              uses_rt_id;
    logic              memread_ex;
    logic [REG_AW-1:0] regaddr_ex;
    logic              branch_taken_ex;
    logic              dmem_req_mem;
    logic              dmem_ready;

    logic              hold_pc;
    logic              hold_ifid;
    logic              flush_ifid;
    logic              bubble_idex;
    logic              hold_exmem;
    logic              bubble_memwb;
    logic              mem_err;
    logic [1:0]        ctrl_state;

    modport master (
        output rs_id, rt_id, uses_rt_id, memread_ex, regaddr_ex,
               branch_taken_ex, dmem_req_mem, dmem_ready,
        input  hold_pc, hold_ifid, flush_ifid, bubble_idex, hold_exmem,
               bubble_memwb, mem_err, ctrl_state
    );

    modport slave (
        input  rs_id, rt_id, uses_rt_id, memread_ex, regaddr_ex,
               branch_taken_ex, dmem_req_mem, dmem_ready,
        output hold_pc, hold_ifid, flush_ifid, bubble_idex, hold_exmem,
               bubble_memwb, mem_err, ctrl_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and multi-cycle data-memory waits with timeout.
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit stall counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal flow, hazards detected combinationally each cycle
// S_LU     | second load-use bubble cycle (LU_STALL == 2 only)
// S_MEMW   | waiting on dmem_ready, everything up to MEM/WB frozen
// S_FLUSH  | cycle after a taken branch, wrong-path fetch squashed
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int DMEM_TIMEOUT = 15,
    parameter int LU_STALL     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           lu_stall_cnt,
    output logic [31:0]           mem_wait_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_LU    = 2'b01,
        S_MEMW  = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    localparam int            CW      = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DMEM_TIMEOUT);
    // wait_cnt counts cycles already waited; the current cycle is one more
    localparam logic [CW-1:0] CNT_TC  = CW'(DMEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;

    logic [REG_AW-1:0] rs, rt, ra;
    logic              lu, mw;
    logic              hold_pc_c, hold_ifid_c, flush_ifid_c, bubble_idex_c;
    logic              hold_exmem_c, bubble_memwb_c, mem_err_c;

    assign rs = hz.rs_id;
    assign rt = hz.rt_id;
    assign ra = hz.regaddr_ex;

    assign lu = hz.memread_ex && (ra != '0) &&
                ((ra == rs) || (hz.uses_rt_id && (ra == rt)));
    assign mw = hz.dmem_req_mem && !hz.dmem_ready;

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and hold/bubble enables from state plus live hazards
    always_comb begin
        state_d        = S_RUN;
        wait_cnt_d     = '0;
        hold_pc_c      = 1'b0;
        hold_ifid_c    = 1'b0;
        flush_ifid_c   = 1'b0;
        bubble_idex_c  = 1'b0;
        hold_exmem_c   = 1'b0;
        bubble_memwb_c = 1'b0;
        mem_err_c      = 1'b0;
        case (state_q)
            S_RUN, S_LU: begin
                if (mw) begin
                    // ID/EX is frozen by leaving bubble_idex low
                    hold_pc_c      = 1'b1;
                    hold_ifid_c    = 1'b1;
                    hold_exmem_c   = 1'b1;
                    bubble_memwb_c = 1'b1;
                    state_d        = S_MEMW;
                    wait_cnt_d     = CW'(1);
                end else if (state_q == S_LU) begin
                    hold_pc_c     = 1'b1;
                    hold_ifid_c   = 1'b1;
                    bubble_idex_c = 1'b1;
                end else if (hz.branch_taken_ex) begin
                    flush_ifid_c  = 1'b1;
                    bubble_idex_c = 1'b1;
                    state_d       = S_FLUSH;
                end else if (lu) begin
                    hold_pc_c     = 1'b1;
                    hold_ifid_c   = 1'b1;
                    bubble_idex_c = 1'b1;
                    state_d       = (LU_STALL == 2) ? S_LU : S_RUN;
                end
            end
            S_MEMW: begin
                if (hz.dmem_ready) begin
                    // release now so MEM/WB captures the access result
                end else if (wait_cnt_q >= CNT_TC) begin
                    mem_err_c      = 1'b1;
                    bubble_memwb_c = 1'b1;
                end else begin
                    hold_pc_c      = 1'b1;
                    hold_ifid_c    = 1'b1;
                    hold_exmem_c   = 1'b1;
                    bubble_memwb_c = 1'b1;
                    state_d        = S_MEMW;
                    wait_cnt_d     = (wait_cnt_q == CNT_MAX) ? wait_cnt_q
                                                             : wait_cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                flush_ifid_c = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Reset forces every enable low in the reset cycle itself
    assign hz.hold_pc      = hold_pc_c      & ~rst;
    assign hz.hold_ifid    = hold_ifid_c    & ~rst;
    assign hz.flush_ifid   = flush_ifid_c   & ~rst;
    assign hz.bubble_idex  = bubble_idex_c  & ~rst;
    assign hz.hold_exmem   = hold_exmem_c   & ~rst;
    assign hz.bubble_memwb = bubble_memwb_c & ~rst;
    assign hz.mem_err      = mem_err_c      & ~rst;
    assign hz.ctrl_state   = rst ? 2'b00 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic        lu_hold;
    logic [31:0] lu_cnt_q, mw_cnt_q, fl_cnt_q;

    // Only the load-use case asserts hold_pc together with bubble_idex
    assign lu_hold = hold_pc_c & bubble_idex_c;

    // Saturating per-cause stall cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (lu_hold && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if ((state_q == S_MEMW) && (mw_cnt_q != '1))
                mw_cnt_q <= mw_cnt_q + 32'd1;
            if (flush_ifid_c && (fl_cnt_q != '1))
                fl_cnt_q <= fl_cnt_q + 32'd1;
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign mem_wait_cnt = mw_cnt_q;
    assign flush_cnt    = fl_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default parameters, and
// DMEM_TIMEOUT=3 / LU_STALL=2) share one stimulus stream and are compared
// every cycle against a flag-based behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] rs_id, rt_id, regaddr_ex;
    logic          uses_rt_id, memread_ex, branch_taken_ex;
    logic          dmem_req_mem, dmem_ready;

    pipeline_hazard_ctrl_if #(.REG_AW(AW)) if_a ();
    pipeline_hazard_ctrl_if #(.REG_AW(AW)) if_b ();

    assign if_a.rs_id = rs_id;                     assign if_b.rs_id = rs_id;
    assign if_a.rt_id = rt_id;                     assign if_b.rt_id = rt_id;
    assign if_a.uses_rt_id = uses_rt_id;           assign if_b.uses_rt_id = uses_rt_id;
    assign if_a.memread_ex = memread_ex;           assign if_b.memread_ex = memread_ex;
    assign if_a.regaddr_ex = regaddr_ex;           assign if_b.regaddr_ex = regaddr_ex;
    assign if_a.branch_taken_ex = branch_taken_ex; assign if_b.branch_taken_ex = branch_taken_ex;
    assign if_a.dmem_req_mem = dmem_req_mem;       assign if_b.dmem_req_mem = dmem_req_mem;
    assign if_a.dmem_ready = dmem_ready;           assign if_b.dmem_ready = dmem_ready;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pa_lu, pa_mw, pa_fl, pb_lu, pb_mw, pb_fl;
`endif

    pipeline_hazard_ctrl #(.REG_AW(AW), .DMEM_TIMEOUT(15), .LU_STALL(1)) dut_a (
        .clk(clk), .rst(rst), .hz(if_a)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(pa_lu), .mem_wait_cnt(pa_mw), .flush_cnt(pa_fl)
`endif
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .DMEM_TIMEOUT(3), .LU_STALL(2)) dut_b (
        .clk(clk), .rst(rst), .hz(if_b)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(pb_lu), .mem_wait_cnt(pb_mw), .flush_cnt(pb_fl)
`endif
    );

    // Model: bubbles still owed, cycles already waited, flush owed
    typedef struct {
        int lu_left;
        int waited;
        bit flush_pend;
    } mdl_t;

    mdl_t       ma, mb;
    logic [8:0] smp_a, smp_b;
    int         n_err = 0;
    int         n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector bits: 0 hold_pc, 1 hold_ifid, 2 flush_ifid, 3 bubble_idex,
    // 4 hold_exmem, 5 bubble_memwb, 6 mem_err, 8:7 ctrl_state
    task automatic model_eval(input mdl_t m, input int tmo, input int lus,
                              output logic [8:0] o, output mdl_t n);
        bit lu, mw;
        lu = memread_ex && regaddr_ex != 0 &&
             (regaddr_ex == rs_id || (uses_rt_id && regaddr_ex == rt_id));
        mw = dmem_req_mem && !dmem_ready;
        o = '0;
        n = '{0, 0, 1'b0};
        if (rst) return;
        if (m.flush_pend)       o[8:7] = 2'd3;
        else if (m.waited > 0)  o[8:7] = 2'd2;
        else if (m.lu_left > 0) o[8:7] = 2'd1;
        if (m.flush_pend) begin
            o[2] = 1'b1;
        end else if (m.waited > 0) begin
            if (dmem_ready) begin
                o[6:0] = '0;
            end else if (m.waited + 1 >= tmo) begin
                o[6] = 1'b1; o[5] = 1'b1;
            end else begin
                o[0] = 1'b1; o[1] = 1'b1; o[4] = 1'b1; o[5] = 1'b1;
                n.waited = m.waited + 1;
            end
        end else if (mw) begin
            o[0] = 1'b1; o[1] = 1'b1; o[4] = 1'b1; o[5] = 1'b1;
            n.waited = 1;
        end else if (m.lu_left > 0) begin
            o[0] = 1'b1; o[1] = 1'b1; o[3] = 1'b1;
        end else if (branch_taken_ex) begin
            o[2] = 1'b1; o[3] = 1'b1;
            n.flush_pend = 1'b1;
        end else if (lu) begin
            o[0] = 1'b1; o[1] = 1'b1; o[3] = 1'b1;
            n.lu_left = lus - 1;
        end
    endtask

    task automatic step();
        logic [8:0] ea, eb;
        mdl_t       na, nb;
        @(negedge clk);
        model_eval(ma, 15, 1, ea, na);
        model_eval(mb, 3, 2, eb, nb);
        smp_a = {if_a.ctrl_state, if_a.mem_err, if_a.bubble_memwb, if_a.hold_exmem,
                 if_a.bubble_idex, if_a.flush_ifid, if_a.hold_ifid, if_a.hold_pc};
        smp_b = {if_b.ctrl_state, if_b.mem_err, if_b.bubble_memwb, if_b.hold_exmem,
                 if_b.bubble_idex, if_b.flush_ifid, if_b.hold_ifid, if_b.hold_pc};
        chk("dut_a_vs_model", 32'(smp_a), 32'(ea));
        chk("dut_b_vs_model", 32'(smp_b), 32'(eb));
        @(posedge clk);
        ma = na;
        mb = nb;
        #1;
    endtask

    task automatic idle();
        rs_id = '0; rt_id = '0; regaddr_ex = '0; uses_rt_id = 1'b0;
        memread_ex = 1'b0; branch_taken_ex = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        ma = '{0, 0, 1'b0};
        mb = '{0, 0, 1'b0};
        rst = 1'b1;
        idle();
        step();
        step();
        chk("reset_state", 32'(smp_a), 32'd0);
        rst = 1'b0;
        step();

        // load-use on rs
        memread_ex = 1'b1; regaddr_ex = 5'd5; rs_id = 5'd5;
        step();
        chk("lu_a_stall", 32'(smp_a[3:0]), 32'hB);
        idle();
        step();
        chk("lu_a_release", 32'(smp_a[3:0]), 32'h0);
        chk("lu_b_second", 32'(smp_b), {23'd0, 2'd1, 7'h0B});
        step();

        // r0 destination never stalls
        memread_ex = 1'b1; regaddr_ex = 5'd0; rs_id = 5'd0;
        step();
        chk("lu_r0_nostall", 32'(smp_a[0]), 32'd0);

        // rt match without rt use
        memread_ex = 1'b1; regaddr_ex = 5'd7; rt_id = 5'd7; rs_id = 5'd3; uses_rt_id = 1'b0;
        step();
        chk("rt_unused_nostall", 32'(smp_a[0]), 32'd0);
        uses_rt_id = 1'b1;
        step();
        chk("rt_used_stall", 32'(smp_a[0]), 32'd1);
        idle();
        step();
        step();

        // taken branch
        branch_taken_ex = 1'b1;
        step();
        chk("br_first", 32'(smp_a), {23'd0, 2'd0, 7'h0C});
        branch_taken_ex = 1'b0;
        step();
        chk("br_second", 32'(smp_a), {23'd0, 2'd3, 7'h04});
        step();
        chk("br_done", 32'(smp_a[8:7]), 32'd0);

        // memory wait for 4 cycles, ready on the 5th
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mw_hold", 32'(smp_a[6:0]), 32'h33);
            if (i == 2) chk("tmo_err_b", 32'(smp_b[6:5]), 32'd3);
        end
        dmem_ready = 1'b1;
        step();
        chk("mw_release", 32'(smp_a[6:0]), 32'h0);
        idle();
        step();

        // branch and memory wait together, then reset mid-wait
        branch_taken_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        step();
        chk("prio_no_flush", 32'(smp_a[2]), 32'd0);
        step();
        chk("prio_memwait", 32'(smp_a[8:7]), 32'd2);
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_wait", 32'(smp_a), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 63) == 0);
            rs_id           = AW'($urandom_range(0, 3));
            rt_id           = AW'($urandom_range(0, 3));
            regaddr_ex      = AW'($urandom_range(0, 3));
            uses_rt_id      = 1'($urandom_range(0, 1));
            memread_ex      = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            dmem_req_mem    = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
